game_flow_ctrl: RTL and testbench
=================================

Name: game_flow_ctrl

Overview:
- Top-level sequencer for the Sudoku display datapath.
- Owns the screen state (MENU / GAME / OVER) fed to the pixel generator, and the BCD MM:SS play timer shown on the game and over screens.
- Owns the local connect request, and issues one-cycle control pulses to the board logic and to the link transmitter.
- Sits between the mouse/board-checker/link receiver and the pixel generator.

Parameters:
- TICKS_PER_SEC, 100000000: clka cycles per timer second. Must be ≥2; benches use 4.

Ports:
- clka, input, 1: system clock; all logic on rising edge.
- rst, input, 1: synchronous, active-high reset.
- MOUSE_LEFT, input, 1: raw left-button level, already synchronous to clka.
- mouse_on_start_button, input, 1: cursor over the START button (menu).
- mouse_on_connect_button, input, 1: cursor over the CONNECT button (menu).
- mouse_on_return_button, input, 1: cursor over the RETURN button (over screen).
- board_solved, input, 1: level from the board checker; 1 = board complete and valid.
- receive_connect, input, 1: peer has connected (link level).
- receive_start, input, 1: one-cycle pulse; peer started a game.
- state, output, 2: 0 = SMENU, 1 = SGAME, 2 = SOVER; registered.
- send_connect, output, 1: local connect request level; registered.
- send_start, output, 1: one-cycle pulse to the link; local start while connected.
- new_game, output, 1: one-cycle pulse telling the board logic to load a fresh puzzle.
- time_spent, output, 16: BCD {min_tens, min_ones, sec_tens, sec_ones}; registered.

Behaviour:
Reset (rst=1 at a clock edge, any state):
- state=SMENU, time_spent=16'h0000, send_connect=0, send_start=0, new_game=0.
- Tick counter=0, click-edge register=0.
- Applies mid-game; the timer is discarded.

Click detection:
- Register prev_left <= MOUSE_LEFT every cycle.
- click = MOUSE_LEFT & ~prev_left, evaluated with the button flags in the same cycle.
- A held button yields exactly one click.
- Holding the button across a state change does not re-trigger.

SMENU:
- Start condition: (click & mouse_on_start_button) or (receive_start & receive_connect).
- On start, at the next edge:
  - state=SGAME, time_spent=0, tick counter=0.
  - new_game=1 for exactly that one cycle.
- send_start=1 for the same cycle only if the start came from a local click and send_connect=1.
- A peer-initiated start never asserts send_start.
- click & mouse_on_connect_button with no start condition toggles send_connect at the next edge.
- If a start and a connect click coincide, the start wins and send_connect is unchanged.
- receive_start while receive_connect=0 is ignored.

SGAME:
- Tick counter increments every cycle and wraps at TICKS_PER_SEC-1.
- On the wrap cycle, time_spent increments in BCD:
  - sec_ones 9 -> 0 carries into sec_tens.
  - sec_tens 5 -> 0 carries into min_ones.
  - min_ones 9 -> 0 carries into min_tens.
- Saturation: at 16'h9959 the timer holds; it never wraps to 0000.
- board_solved=1: state=SOVER at the next edge. Any increment scheduled for that same edge is suppressed, so the displayed time is frozen at its pre-edge value.
- Clicks and receive_start are ignored in SGAME.

SOVER:
- time_spent holds.
- click & mouse_on_return_button: state=SMENU at the next edge.
- time_spent keeps its value until the next game start clears it.
- send_connect is retained across all state changes; only a menu toggle or rst changes it.

General:
- State value 3 is unreachable; if it is ever present, go to SMENU at the next edge with no pulses.
- Latency is exactly one cycle from the qualifying input cycle to the registered output change.
- new_game and send_start are never asserted outside the SMENU->SGAME transition cycle.

Test Plan:
1. Reset, MOUSE_LEFT 0->1 with mouse_on_start_button=1: next cycle state=1, new_game=1 for 1 cycle, send_start=0, time_spent=0000. Holding MOUSE_LEFT for 10 cycles gives no further pulses.
2. In SMENU, two separate clicks on CONNECT: send_connect goes 0->1->0. With send_connect=1, a start click gives send_start=1 and new_game=1 on the same single cycle.
3. TICKS_PER_SEC=4, in SGAME run 240 cycles: time_spent=0100. Preload to 0959 and run 4 more cycles: 1000. At 9959, run 40 cycles: stays 9959.
4. In SGAME at 0012, assert board_solved on a tick-wrap cycle: state=2 next cycle, time_spent=0012. Return click: state=0 and time_spent still 0012. Next start: time_spent=0000.
5. receive_start pulse with receive_connect=0: state stays 0. With receive_connect=1: state=1, new_game=1, send_start=0.
6. rst=1 asserted mid-SGAME at 0037 with send_connect=1: next cycle state=0, time_spent=0000, send_connect=0, no pulses.

Source files
------------

// File: rtl/game_flow_ctrl.sv
// Top-level flow sequencer for the Sudoku display: MENU/GAME/OVER screen state,
// BCD MM:SS play timer, local connect request and one-cycle start pulses.
module game_flow_ctrl #(
  parameter int TICKS_PER_SEC = 100000000
) (
  input  logic        clka,
  input  logic        rst,
  input  logic        MOUSE_LEFT,
  input  logic        mouse_on_start_button,
  input  logic        mouse_on_connect_button,
  input  logic        mouse_on_return_button,
  input  logic        board_solved,
  input  logic        receive_connect,
  input  logic        receive_start,
  output logic [1:0]  state,
  output logic        send_connect,
  output logic        send_start,
  output logic        new_game,
  output logic [15:0] time_spent
);

  localparam int TW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(TICKS_PER_SEC - 1);
  localparam logic [15:0]   TIME_SAT = 16'h9959;

  typedef enum logic [1:0] {
    SMENU = 2'd0,
    SGAME = 2'd1,
    SOVER = 2'd2,
    SBAD  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [15:0]   time_q, time_d;
  logic          send_connect_q, send_connect_d;
  logic          send_start_q, send_start_d;
  logic          new_game_q, new_game_d;
  logic          prev_left_q, prev_left_d;

  logic click, local_start, peer_start, wrap;

  // One-second BCD increment; minutes carry stops at the tens digit,
  // saturation at 99:59 is handled by the caller.
  function automatic logic [15:0] bcd_inc(input logic [15:0] t);
    logic [3:0] m1, m0, s1, s0;
    {m1, m0, s1, s0} = t;
    if (s0 != 4'd9) s0 = s0 + 4'd1;
    else begin
      s0 = 4'd0;
      if (s1 != 4'd5) s1 = s1 + 4'd1;
      else begin
        s1 = 4'd0;
        if (m0 != 4'd9) m0 = m0 + 4'd1;
        else begin
          m0 = 4'd0;
          m1 = m1 + 4'd1;
        end
      end
    end
    return {m1, m0, s1, s0};
  endfunction

  assign click       = MOUSE_LEFT & ~prev_left_q;
  assign local_start = click & mouse_on_start_button;
  assign peer_start  = receive_start & receive_connect;
  assign wrap        = (tick_q == TICK_MAX);

  always_comb begin
    state_d        = state_q;
    tick_d         = tick_q;
    time_d         = time_q;
    send_connect_d = send_connect_q;
    send_start_d   = 1'b0;
    new_game_d     = 1'b0;
    prev_left_d    = MOUSE_LEFT;
    case (state_q)
      SMENU: begin
        if (local_start || peer_start) begin
          state_d      = SGAME;
          time_d       = 16'h0000;
          tick_d       = '0;
          new_game_d   = 1'b1;
          send_start_d = local_start & send_connect_q;
        end else if (click && mouse_on_connect_button) begin
          send_connect_d = ~send_connect_q;
        end
      end
      SGAME: begin
        tick_d = wrap ? '0 : tick_q + 1'b1;
        // Solving freezes the display at its pre-edge value.
        if (board_solved) state_d = SOVER;
        else if (wrap && time_q != TIME_SAT) time_d = bcd_inc(time_q);
      end
      SOVER: begin
        if (click && mouse_on_return_button) state_d = SMENU;
      end
      default: state_d = SMENU;
    endcase
  end

  always_ff @(posedge clka) begin
    if (rst) begin
      state_q        <= SMENU;
      tick_q         <= '0;
      time_q         <= 16'h0000;
      send_connect_q <= 1'b0;
      send_start_q   <= 1'b0;
      new_game_q     <= 1'b0;
      prev_left_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      tick_q         <= tick_d;
      time_q         <= time_d;
      send_connect_q <= send_connect_d;
      send_start_q   <= send_start_d;
      new_game_q     <= new_game_d;
      prev_left_q    <= prev_left_d;
    end
  end

  assign state        = state_q;
  assign send_connect = send_connect_q;
  assign send_start   = send_start_q;
  assign new_game     = new_game_q;
  assign time_spent   = time_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed-vector bench for game_flow_ctrl with TICKS_PER_SEC=4 (4 cycles per second).
module tb_game_flow_ctrl;

  logic        clka = 1'b0;
  logic        rst = 1'b1;
  logic        MOUSE_LEFT = 1'b0;
  logic        mouse_on_start_button = 1'b0;
  logic        mouse_on_connect_button = 1'b0;
  logic        mouse_on_return_button = 1'b0;
  logic        board_solved = 1'b0;
  logic        receive_connect = 1'b0;
  logic        receive_start = 1'b0;
  logic [1:0]  state;
  logic        send_connect, send_start, new_game;
  logic [15:0] time_spent;

  int n_vec = 0;
  int n_err = 0;

  game_flow_ctrl #(.TICKS_PER_SEC(4)) dut (
    .clka                    (clka),
    .rst                     (rst),
    .MOUSE_LEFT              (MOUSE_LEFT),
    .mouse_on_start_button   (mouse_on_start_button),
    .mouse_on_connect_button (mouse_on_connect_button),
    .mouse_on_return_button  (mouse_on_return_button),
    .board_solved            (board_solved),
    .receive_connect         (receive_connect),
    .receive_start           (receive_start),
    .state                   (state),
    .send_connect            (send_connect),
    .send_start              (send_start),
    .new_game                (new_game),
    .time_spent              (time_spent)
  );

  always #5 clka = ~clka;

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // Advance one edge; outputs are stable 1 time unit later.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clka);
      #1;
    end
  endtask

  task automatic chk_pulses(input string tag, input logic ng, input logic ss);
    chk({tag, "_ng"}, {15'd0, new_game}, {15'd0, ng});
    chk({tag, "_ss"}, {15'd0, send_start}, {15'd0, ss});
  endtask

  int pulses;

  initial begin
    // Reset
    step(2);
    rst = 1'b0;
    chk("rst_state", {14'd0, state}, 16'd0);
    chk("rst_time", time_spent, 16'h0000);
    chk("rst_sc", {15'd0, send_connect}, 16'd0);
    chk_pulses("rst", 1'b0, 1'b0);

    // Local start click, no connect
    mouse_on_start_button = 1'b1;
    MOUSE_LEFT = 1'b1;
    step();
    chk("start_state", {14'd0, state}, 16'd1);
    chk_pulses("start", 1'b1, 1'b0);
    chk("start_time", time_spent, 16'h0000);
    // Held button: no re-trigger; also check the first-second boundary
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      pulses += int'(new_game) + int'(send_start);
      if (i == 2) chk("sec_edge_pre", time_spent, 16'h0000);
      if (i == 3) chk("sec_edge_post", time_spent, 16'h0001);
    end
    chk("hold_pulses", 16'(pulses), 16'd0);
    chk("hold_state", {14'd0, state}, 16'd1);

    // Timer: 240 cycles -> 01:00, then 09:59 -> 10:00, then saturate at 99:59
    step(230);
    chk("t_0100", time_spent, 16'h0100);
    step(2396 - 240);
    chk("t_0959", time_spent, 16'h0959);
    step(4);
    chk("t_1000", time_spent, 16'h1000);
    step(23996 - 2400);
    chk("t_9959", time_spent, 16'h9959);
    step(40);
    chk("t_sat", time_spent, 16'h9959);
    chk("t_sat_state", {14'd0, state}, 16'd1);

    // Connect toggles
    MOUSE_LEFT = 1'b0;
    mouse_on_start_button = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    mouse_on_connect_button = 1'b1;
    MOUSE_LEFT = 1'b1; step();
    chk("conn_on", {15'd0, send_connect}, 16'd1);
    MOUSE_LEFT = 1'b0; step();
    MOUSE_LEFT = 1'b1; step();
    chk("conn_off", {15'd0, send_connect}, 16'd0);
    MOUSE_LEFT = 1'b0; step();
    MOUSE_LEFT = 1'b1; step();
    chk("conn_on2", {15'd0, send_connect}, 16'd1);
    chk("conn_state", {14'd0, state}, 16'd0);
    MOUSE_LEFT = 1'b0; step();

    // Start while connected: send_start with new_game, one cycle
    mouse_on_connect_button = 1'b0;
    mouse_on_start_button = 1'b1;
    MOUSE_LEFT = 1'b1; step();
    chk("cstart_state", {14'd0, state}, 16'd1);
    chk_pulses("cstart", 1'b1, 1'b1);
    step();
    chk_pulses("cstart_after", 1'b0, 1'b0);
    // Run to 00:37 (148 cycles after start), then reset mid-game
    step(147);
    chk("t_0037", time_spent, 16'h0037);
    chk("t_0037_sc", {15'd0, send_connect}, 16'd1);
    rst = 1'b1; step();
    rst = 1'b0;
    chk("mrst_state", {14'd0, state}, 16'd0);
    chk("mrst_time", time_spent, 16'h0000);
    chk("mrst_sc", {15'd0, send_connect}, 16'd0);
    chk_pulses("mrst", 1'b0, 1'b0);

    // Start and connect click together: start wins, connect unchanged
    MOUSE_LEFT = 1'b0; step();
    mouse_on_connect_button = 1'b1;
    MOUSE_LEFT = 1'b1; step();
    chk("coin_state", {14'd0, state}, 16'd1);
    chk("coin_sc", {15'd0, send_connect}, 16'd0);
    chk_pulses("coin", 1'b1, 1'b0);
    mouse_on_connect_button = 1'b0;
    mouse_on_start_button = 1'b0;
    MOUSE_LEFT = 1'b0;

    // Solve on the wrap cycle that would have produced 00:13
    step(51);
    chk("t_0012", time_spent, 16'h0012);
    board_solved = 1'b1; step();
    chk("solve_state", {14'd0, state}, 16'd2);
    chk("solve_time", time_spent, 16'h0012);
    step(8);
    chk("over_hold", time_spent, 16'h0012);
    board_solved = 1'b0;
    mouse_on_return_button = 1'b1;
    MOUSE_LEFT = 1'b1; step();
    chk("ret_state", {14'd0, state}, 16'd0);
    chk("ret_time", time_spent, 16'h0012);
    mouse_on_return_button = 1'b0;
    MOUSE_LEFT = 1'b0; step();
    mouse_on_start_button = 1'b1;
    MOUSE_LEFT = 1'b1; step();
    chk("restart_state", {14'd0, state}, 16'd1);
    chk("restart_time", time_spent, 16'h0000);
    mouse_on_start_button = 1'b0;
    MOUSE_LEFT = 1'b0;

    // Peer start gated by receive_connect
    rst = 1'b1; step();
    rst = 1'b0;
    receive_start = 1'b1; step();
    receive_start = 1'b0;
    chk("peer_nc_state", {14'd0, state}, 16'd0);
    chk_pulses("peer_nc", 1'b0, 1'b0);
    step();
    receive_connect = 1'b1;
    receive_start = 1'b1; step();
    receive_start = 1'b0;
    chk("peer_state", {14'd0, state}, 16'd1);
    chk_pulses("peer", 1'b1, 1'b0);

    // Clicks in SGAME are ignored
    mouse_on_connect_button = 1'b1;
    mouse_on_start_button = 1'b1;
    MOUSE_LEFT = 1'b1; step();
    chk("game_click_sc", {15'd0, send_connect}, 16'd0);
    chk_pulses("game_click", 1'b0, 1'b0);
    chk("game_click_state", {14'd0, state}, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
